// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU vs. load-return with starvation guard, plus pending-load scoreboard.
// Optional macro RF_WB_BYPASS_EN adds combinational write-to-read forwarding ports.
module rf_wb_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             ld_issue,
    input  logic [4:0]       ld_issue_rd,
    input  logic [4:0]       RS1,
    input  logic [4:0]       RS2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             write_en,
    output logic [4:0]       RD,
    output logic [WIDTH-1:0] rf_wdata
`ifdef RF_WB_BYPASS_EN
    ,
    output logic             rs1_fwd_valid,
    output logic             rs2_fwd_valid,
    output logic [WIDTH-1:0] rs1_fwd_data,
    output logic [WIDTH-1:0] rs2_fwd_data
`endif
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // A requester seeing ready=0 holds valid, rd and data stable.
    logic [3:0]  wait_cnt;
    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        starved;
    logic        alu_xfer;
    logic        mem_xfer;

    always_comb begin
        starved   = (wait_cnt == MAX_CNT);
        alu_ready = rst && alu_valid && (!mem_valid || starved);
        mem_ready = rst && mem_valid && !(alu_valid && starved);
        alu_xfer  = alu_valid && alu_ready;
        mem_xfer  = mem_valid && mem_ready;
    end

    // Clear before set so a load issued on the same edge as an older return stays pending.
    always_comb begin
        busy_next = busy;
        if (mem_xfer) busy_next[mem_rd] = 1'b0;
        if (ld_issue && (ld_issue_rd != 5'd0)) busy_next[ld_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        rs1_busy = (RS1 != 5'd0) && busy[RS1];
        rs2_busy = (RS2 != 5'd0) && busy[RS2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (alu_valid && !alu_ready) begin
            if (wait_cnt != MAX_CNT) wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_en <= 1'b0;
            RD       <= 5'd0;
            rf_wdata <= '0;
        end else if (alu_xfer) begin
            write_en <= (alu_rd != 5'd0);
            if (alu_rd != 5'd0) begin
                RD       <= alu_rd;
                rf_wdata <= alu_data;
            end
        end else if (mem_xfer) begin
            write_en <= (mem_rd != 5'd0);
            if (mem_rd != 5'd0) begin
                RD       <= mem_rd;
                rf_wdata <= mem_data;
            end
        end else begin
            write_en <= 1'b0;
        end
    end

`ifdef RF_WB_BYPASS_EN
    always_comb begin
        rs1_fwd_valid = write_en && (RD == RS1) && (RS1 != 5'd0);
        rs2_fwd_valid = write_en && (RD == RS2) && (RS2 != 5'd0);
        rs1_fwd_data  = rf_wdata;
        rs2_fwd_data  = rf_wdata;
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, ALU write, starvation, scoreboard, x0, bypass, mid-stream reset.
module tb_rf_wb_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, alu_ready;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             mem_valid, mem_ready;
    logic [4:0]       mem_rd;
    logic [WIDTH-1:0] mem_data;
    logic             ld_issue;
    logic [4:0]       ld_issue_rd;
    logic [4:0]       RS1, RS2;
    logic             rs1_busy, rs2_busy;
    logic             write_en;
    logic [4:0]       RD;
    logic [WIDTH-1:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
    logic             rs1_fwd_valid, rs2_fwd_valid;
    logic [WIDTH-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .RS1(RS1), .RS2(RS2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_en(write_en), .RD(RD), .rf_wdata(rf_wdata)
`ifdef RF_WB_BYPASS_EN
        ,
        .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        RS1 = 0; RS2 = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        alu_valid = 1; mem_valid = 1; alu_rd = 4; mem_rd = 6;
        #3;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en got=%0b exp=0", write_en); end
        checks++; if (RD !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", RD); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got=%0b exp=0", alu_ready); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got=%0b exp=0", mem_ready); end
        tick();
        idle_inputs();
        rst = 1;
        tick();
    endtask

    task automatic test_alu_single();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got=%0b exp=1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL alu_write_en got=%0b exp=1", write_en); end
        checks++; if (RD !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", RD); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wdata got=%h exp=deadbeef", rf_wdata); end
        tick();
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL alu_idle_we got=%0b exp=0", write_en); end
        checks++; if (RD !== 5'd5) begin errors++; $display("FAIL alu_rd_hold got=%0d exp=5", RD); end
    endtask

    task automatic test_starvation();
        // Expected winners with both requesting: mem x3, alu, then mem again (counter restarted).
        logic exp_alu [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        alu_valid = 1; alu_rd = 1; alu_data = 32'hAAAA0001;
        mem_valid = 1; mem_rd = 2; mem_data = 32'hBBBB0002;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (alu_ready !== exp_alu[i] || mem_ready !== !exp_alu[i]) begin
                errors++;
                $display("FAIL starve_grant[%0d] got alu=%0b mem=%0b exp alu=%0b", i, alu_ready, mem_ready, exp_alu[i]);
            end
            tick();
            checks++;
            if (write_en !== 1'b1 || RD !== (exp_alu[i] ? 5'd1 : 5'd2)) begin
                errors++;
                $display("FAIL starve_write[%0d] got we=%0b rd=%0d exp we=1 rd=%0d", i, write_en, RD, exp_alu[i] ? 1 : 2);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        ld_issue = 1; ld_issue_rd = 7; RS1 = 7; RS2 = 7;
        #1;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_before got=%0b exp=0", rs1_busy); end
        tick();
        ld_issue = 0;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_rs1_set got=%0b exp=1", rs1_busy); end
        checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_rs2_set got=%0b exp=1", rs2_busy); end
        mem_valid = 1; mem_rd = 7; mem_data = 32'h00001234;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL sb_mem_ready got=%0b exp=1", mem_ready); end
        tick();
        mem_valid = 0;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear got=%0b exp=0", rs1_busy); end
        checks++; if (write_en !== 1'b1 || RD !== 5'd7 || rf_wdata !== 32'h00001234) begin
            errors++; $display("FAIL sb_write got we=%0b rd=%0d data=%h exp we=1 rd=7 data=00001234", write_en, RD, rf_wdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_same_edge();
        ld_issue = 1; ld_issue_rd = 9; RS1 = 9;
        tick();
        // Second issue to an already-busy register, together with the return of the first.
        mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
        tick();
        ld_issue = 0; mem_valid = 0;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL same_edge_set_wins got=%0b exp=1", rs1_busy); end
        // Double issue with no return in between: one return must fully clear (no counting).
        ld_issue = 1;
        tick();
        ld_issue = 0;
        mem_valid = 1;
        tick();
        mem_valid = 0;
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL no_count_clear got=%0b exp=0", rs1_busy); end
        // Clearing a non-busy bit is harmless.
        mem_valid = 1; mem_rd = 20; RS2 = 20;
        tick();
        mem_valid = 0;
        checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL clear_idle got=%0b exp=0", rs2_busy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        alu_valid = 1; alu_rd = 0; alu_data = 32'hCAFE0000;
        ld_issue = 1; ld_issue_rd = 0; RS1 = 0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%0b exp=1", alu_ready); end
        tick();
        alu_valid = 0; ld_issue = 0;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL x0_write_en got=%0b exp=0", write_en); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got=%0b exp=0", rs1_busy); end
        idle_inputs();
        tick();
    endtask

`ifdef RF_WB_BYPASS_EN
    task automatic test_bypass();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33333333;
        tick();
        alu_valid = 0; RS1 = 4; RS2 = 3;
        #1;
        checks++; if (rs2_fwd_valid !== 1'b1 || rs2_fwd_data !== 32'h33333333) begin
            errors++; $display("FAIL bypass_rs2 got v=%0b d=%h exp v=1 d=33333333", rs2_fwd_valid, rs2_fwd_data);
        end
        checks++; if (rs1_fwd_valid !== 1'b0) begin errors++; $display("FAIL bypass_rs1 got=%0b exp=0", rs1_fwd_valid); end
        tick();
        checks++; if (rs2_fwd_valid !== 1'b0) begin errors++; $display("FAIL bypass_idle got=%0b exp=0", rs2_fwd_valid); end
        idle_inputs();
    endtask
`endif

    task automatic test_reset_mid();
        ld_issue = 1; ld_issue_rd = 12; RS1 = 12;
        alu_valid = 1; alu_rd = 11; alu_data = 32'h11110000;
        tick();
        ld_issue = 0;
        alu_rd = 10; alu_data = 32'h10101010;
        checks++; if (write_en !== 1'b1 || rs1_busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset got we=%0b busy=%0b exp we=1 busy=1", write_en, rs1_busy);
        end
        #2;
        rst = 0;
        #1;
        checks++; if (write_en !== 1'b0 || RD !== 5'd0) begin
            errors++; $display("FAIL mid_reset_write got we=%0b rd=%0d exp we=0 rd=0", write_en, RD);
        end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%0b exp=0", rs1_busy); end
        idle_inputs();
        tick();
        rst = 1;
        tick();
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL post_reset_we got=%0b exp=0", write_en); end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_starvation();
        test_scoreboard();
        test_same_edge();
        test_x0();
`ifdef RF_WB_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single register-file write port and shares it between two writeback requesters: the ALU result path and the data-memory load-return path.
- Holds a 32-entry pending-load scoreboard so decode can stall on RS1/RS2 operands that are still awaiting load data.
- Sits between the execute/memory stages and the register file, driving write_en/RD/write data.

Parameters:
- WIDTH, 32, datapath/register width.
- MAX_WAIT, 3, max consecutive cycles a valid ALU request may lose to memory before it is forced to win (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  WIDTH  ALU result.
- mem_valid  input  1  load-return writeback request.
- mem_ready  output  1  load return accepted this cycle.
- mem_rd  input  5  load destination register.
- mem_data  input  WIDTH  load data (dmu output).
- ld_issue  input  1  a load is issued this cycle.
- ld_issue_rd  input  5  destination of the issued load.
- RS1, RS2  input  5 each  decode source register indices.
- rs1_busy, rs2_busy  output  1 each  source register has a pending load.
- write_en  output  1  register-file write strobe (registered).
- RD  output  5  register-file write index (registered).
- rf_wdata  output  WIDTH  register-file write data (registered).
- rs1_fwd_valid, rs2_fwd_valid  output  1 each  forward hit. Present only with RF_WB_BYPASS_EN.
- rs1_fwd_data, rs2_fwd_data  output  WIDTH each  forward data. Present only with RF_WB_BYPASS_EN.

Behaviour:
- Reset (rst low, async):
  - write_en=0, RD=0, rf_wdata=0.
  - All scoreboard bits cleared; starvation counter=0.
  - alu_ready=0 and mem_ready=0 while rst is low.
- Handshake:
  - A transfer occurs when valid&&ready at a rising edge.
  - Ready outputs are combinational from valid inputs and the starvation counter.
  - A requester that sees ready=0 must hold valid, rd and data stable.
- Arbitration (at most one grant per cycle):
  - starved = (wait_cnt == MAX_WAIT).
  - mem_ready = mem_valid && !(alu_valid && starved).
  - alu_ready = alu_valid && (!mem_valid || starved).
- Starvation counter:
  - Increments when alu_valid && !alu_ready, saturating at MAX_WAIT.
  - Clears when the ALU is granted or alu_valid is low.
- Latency:
  - A grant at edge N drives write_en=1 with the winner's RD/data during cycle N+1 (one cycle).
  - write_en=0 in any cycle following no grant.
  - RD and rf_wdata hold their last values when idle.
- x0 handling:
  - A request with rd=0 is accepted normally (ready asserted) but produces write_en=0.
  - The scoreboard is not touched.
- Scoreboard:
  - busy[ld_issue_rd] set at the edge where ld_issue=1 and ld_issue_rd!=0.
  - busy[mem_rd] cleared at the edge where the mem transfer completes.
  - Same-edge set and clear on the same index: set wins (a newer load is outstanding).
  - ld_issue to an already-busy register leaves it busy (no counting).
  - Clearing a non-busy bit is harmless.
  - rsX_busy = busy[RSx] combinationally; forced 0 when RSx=0.
- Reset mid-transfer: any accepted-but-unwritten result is dropped and write_en goes to 0 immediately.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - rsX_fwd_valid = write_en && (RD==RSx) && (RSx!=0); rsX_fwd_data = rf_wdata.
  - Combinational, covering the write-before-read cycle of the register file.
  - rsX_busy is unaffected.
- Undefined: the forwarding ports and logic do not exist; the module is otherwise identical.

Test Plan:
- Reset, then a single ALU request (rd=5, data=0xDEADBEEF) -> alu_ready=1 that cycle; next cycle write_en=1, RD=5, rf_wdata=0xDEADBEEF; following cycle write_en=0.
- alu_valid and mem_valid held high together, MAX_WAIT=3 -> mem granted on 3 consecutive cycles, ALU granted on the 4th; counter then restarts from 0.
- ld_issue with rd=7; RS1=7 -> rs1_busy=1 from the next cycle; mem return to rd=7 accepted -> rs1_busy=0 on the following cycle and write_en=1, RD=7.
- Same edge: ld_issue rd=9 and mem transfer to rd=9 -> busy[9] remains 1.
- ALU request with rd=0 -> alu_ready=1, write_en stays 0; RS1=0 never reports busy.
- With RF_WB_BYPASS_EN: write_en=1, RD=3, RS2=3 -> rs2_fwd_valid=1 and rs2_fwd_data=rf_wdata. Assert rst low mid-stream -> write_en=0 and all busy bits 0 immediately.
